// File: rtl/data_memory_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data-memory controller (slave).
interface data_memory_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 11
);
    logic                  i_mem_read;
    logic                  i_mem_write;
    logic [1:0]            i_size;
    logic                  i_unsigned;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [31:0]           i_mem_write_data;
    logic                  o_stall;
    logic                  o_ready;
    logic [31:0]           o_mem_read_data;
    logic                  o_misaligned;

    modport master (
        output i_mem_read, i_mem_write, i_size, i_unsigned, i_address, i_mem_write_data,
        input  o_stall, o_ready, o_mem_read_data, o_misaligned
    );

    modport slave (
        input  i_mem_read, i_mem_write, i_size, i_unsigned, i_address, i_mem_write_data,
        output o_stall, o_ready, o_mem_read_data, o_misaligned
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Data-memory controller with byte lanes, extended sub-word loads and wait states.
// Define DMEM_MISALIGN_TRAP_EN to suppress and flag misaligned half/word accesses.
module data_memory_ctrl #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic               clk,
    input logic               reset,
    data_memory_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    localparam int unsigned IdxW    = ADDR_WIDTH - 2;
    localparam logic [2:0]  CntInit = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t                r_state, w_state_next;
    logic [2:0]            r_cnt, w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [31:0]           r_wdata;
    logic                  r_is_write;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH] = '{default: '0};

    logic                  w_req, w_capture, w_enter_resp;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [1:0]            w_size;
    logic                  w_unsigned;
    logic [31:0]           w_wdata;
    logic                  w_is_write;
    logic [IdxW-1:0]       w_idx;
    logic [1:0]            w_lane;
    logic                  w_word_acc, w_half_acc, w_misaligned;
    logic [3:0]            w_be;
    logic [31:0]           w_wrep, w_word, w_load;
    logic [15:0]           w_half;
    logic [7:0]            w_byte;

    assign w_req = bus.i_mem_read | bus.i_mem_write;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_enter_resp = 1'b0;
        bus.o_stall  = 1'b0;
        bus.o_ready  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_capture   = 1'b1;
                    bus.o_stall = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_next = StResp;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = StWait;
                        w_cnt_next   = CntInit;
                    end
                end
            end
            StWait: begin
                bus.o_stall = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_next = StResp;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            StResp: begin
                bus.o_ready  = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // With zero wait states the access completes straight from IDLE, before capture.
    assign w_addr     = (r_state == StIdle) ? bus.i_address        : r_addr;
    assign w_size     = (r_state == StIdle) ? bus.i_size           : r_size;
    assign w_unsigned = (r_state == StIdle) ? bus.i_unsigned       : r_unsigned;
    assign w_wdata    = (r_state == StIdle) ? bus.i_mem_write_data : r_wdata;
    assign w_is_write = (r_state == StIdle) ? bus.i_mem_write      : r_is_write;

    assign w_idx      = w_addr[ADDR_WIDTH-1:2];
    assign w_lane     = w_addr[1:0];
    assign w_word_acc = w_size[1];
    assign w_half_acc = (w_size == 2'b01);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misaligned = (w_half_acc & w_lane[0]) | (w_word_acc & (w_lane != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        if (w_word_acc) begin
            w_be   = 4'b1111;
            w_wrep = w_wdata;
        end else if (w_half_acc) begin
            w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wrep = {2{w_wdata[15:0]}};
        end else begin
            w_be   = 4'b0001 << w_lane;
            w_wrep = {4{w_wdata[7:0]}};
        end
    end

    assign w_word = r_mem[w_idx];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];

    always_comb begin
        if (w_misaligned) begin
            w_load = 32'h0;
        end else if (w_word_acc) begin
            w_load = w_word;
        end else if (w_half_acc) begin
            w_load = {{16{~w_unsigned & w_half[15]}}, w_half};
        end else begin
            w_load = {{24{~w_unsigned & w_byte[7]}}, w_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'h0;
            r_is_write <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_addr     <= bus.i_address;
                r_size     <= bus.i_size;
                r_unsigned <= bus.i_unsigned;
                r_wdata    <= bus.i_mem_write_data;
                r_is_write <= bus.i_mem_write;
            end
            if (w_enter_resp && !w_is_write) begin
                r_rdata <= w_load;
            end
        end
    end

    // Array is not reset; a reset before the RESP edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_is_write && !w_misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
        end
    end

    assign bus.o_mem_read_data = r_rdata;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mis <= 1'b0;
        end else if (w_enter_resp) begin
            r_mis <= w_misaligned;
        end
    end

    assign bus.o_misaligned = (r_state == StResp) & r_mis;
`else
    assign bus.o_misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: three controllers with 0, 1 and 3 wait states share one
// stimulus port; the instance index equals its wait-state count.
`timescale 1ns/1ps
module tb_data_memory_ctrl;
    localparam int unsigned AW = 11;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          lat;
        int          issue;
        int          vec;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_ctrl_if #(.ADDR_WIDTH(AW)) bus0 ();
    data_memory_ctrl_if #(.ADDR_WIDTH(AW)) bus1 ();
    data_memory_ctrl_if #(.ADDR_WIDTH(AW)) bus3 ();

    data_memory_ctrl #(.DEPTH(512), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    data_memory_ctrl #(.DEPTH(512), .ADDR_WIDTH(AW), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    data_memory_ctrl #(.DEPTH(512), .ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    int          sel     = 1;
    logic        s_rd    = 1'b0;
    logic        s_wr    = 1'b0;
    logic [1:0]  s_size  = 2'b00;
    logic        s_uns   = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [31:0] s_wdata = 32'h0;

    assign bus0.i_mem_read  = s_rd & (sel == 0);
    assign bus1.i_mem_read  = s_rd & (sel == 1);
    assign bus3.i_mem_read  = s_rd & (sel == 3);
    assign bus0.i_mem_write = s_wr & (sel == 0);
    assign bus1.i_mem_write = s_wr & (sel == 1);
    assign bus3.i_mem_write = s_wr & (sel == 3);
    assign bus0.i_size = s_size;  assign bus1.i_size = s_size;  assign bus3.i_size = s_size;
    assign bus0.i_unsigned = s_uns; assign bus1.i_unsigned = s_uns; assign bus3.i_unsigned = s_uns;
    assign bus0.i_address = s_addr; assign bus1.i_address = s_addr; assign bus3.i_address = s_addr;
    assign bus0.i_mem_write_data = s_wdata;
    assign bus1.i_mem_write_data = s_wdata;
    assign bus3.i_mem_write_data = s_wdata;

    logic        m_stall, m_ready, m_mis;
    logic [31:0] m_rdata;

    always_comb begin
        case (sel)
            0: begin
                m_stall = bus0.o_stall; m_ready = bus0.o_ready;
                m_mis   = bus0.o_misaligned; m_rdata = bus0.o_mem_read_data;
            end
            3: begin
                m_stall = bus3.o_stall; m_ready = bus3.o_ready;
                m_mis   = bus3.o_misaligned; m_rdata = bus3.o_mem_read_data;
            end
            default: begin
                m_stall = bus1.o_stall; m_ready = bus1.o_ready;
                m_mis   = bus1.o_misaligned; m_rdata = bus1.o_mem_read_data;
            end
        endcase
    end

    int          n_cmp  = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [31:0] last_rd [4] = '{default: 32'h0};
    int          vec_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every o_ready pops one expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("v%0d.rdata", e.vec), m_rdata, e.rd);
                    check($sformatf("v%0d.misaligned", e.vec), {31'b0, m_mis}, {31'b0, e.mis});
                    check($sformatf("v%0d.latency", e.vec), 32'(cyc - e.issue), 32'(e.lat));
                end
            end
        end
    end

    task automatic access(input int k, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_mis);
        exp_t e;
        int   stalls;
        bit   done;
        @(negedge clk);
        #1;
        sel = k; s_rd = !wr; s_wr = wr; s_size = sz; s_uns = uns; s_addr = a; s_wdata = wd;
        vec_no++;
        if (!wr) last_rd[k] = exp_rd;
        e.rd = last_rd[k]; e.mis = exp_mis; e.lat = k + 1; e.issue = cyc; e.vec = vec_no;
        exp_q.push_back(e);
        stalls = 0;
        #1;
        if (m_stall) stalls++;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (m_ready) done = 1'b1;
            if (m_stall) stalls++;
        end
        if (!done) check($sformatf("v%0d.ready_timeout", vec_no), 32'd0, 32'd1);
        check($sformatf("v%0d.stall_cycles", vec_no), 32'(stalls), 32'(k + 1));
        #1;
        s_rd = 1'b0; s_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst.dut0.flags", {29'b0, bus0.o_stall, bus0.o_ready, bus0.o_misaligned}, 32'h0);
        check("rst.dut1.flags", {29'b0, bus1.o_stall, bus1.o_ready, bus1.o_misaligned}, 32'h0);
        check("rst.dut3.flags", {29'b0, bus3.o_stall, bus3.o_ready, bus3.o_misaligned}, 32'h0);
        check("rst.dut0.rdata", bus0.o_mem_read_data, 32'h0);
        check("rst.dut1.rdata", bus1.o_mem_read_data, 32'h0);
        check("rst.dut3.rdata", bus3.o_mem_read_data, 32'h0);
        #1 reset = 1'b0;

        // One wait state: word, byte and half accesses
        access(1, 1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 32'h0,        0);
        access(1, 0, 2'b10, 0, 11'h010, 32'h0,        32'hDEADBEEF, 0);
        access(1, 1, 2'b00, 0, 11'h012, 32'h1234565A, 32'h0,        0);
        access(1, 0, 2'b10, 0, 11'h010, 32'h0,        32'hDE5ABEEF, 0);
        access(1, 0, 2'b00, 0, 11'h012, 32'h0,        32'h0000005A, 0);
        access(1, 0, 2'b00, 0, 11'h013, 32'h0,        32'hFFFFFFDE, 0);
        access(1, 0, 2'b00, 1, 11'h013, 32'h0,        32'h000000DE, 0);
        access(1, 0, 2'b00, 0, 11'h010, 32'h0,        32'hFFFFFFEF, 0);
        access(1, 1, 2'b01, 0, 11'h022, 32'hABCD8001, 32'h0,        0);
        access(1, 0, 2'b01, 0, 11'h022, 32'h0,        32'hFFFF8001, 0);
        access(1, 0, 2'b01, 1, 11'h022, 32'h0,        32'h00008001, 0);
        access(1, 0, 2'b01, 1, 11'h020, 32'h0,        32'h00000000, 0);
        access(1, 0, 2'b11, 0, 11'h020, 32'h0,        32'h80010000, 0);
        access(1, 1, 2'b10, 0, 11'h040, 32'h55AA55AA, 32'h0,        0);
`ifdef DMEM_MISALIGN_TRAP_EN
        access(1, 1, 2'b10, 0, 11'h041, 32'h11111111, 32'h0,        1);
        access(1, 0, 2'b10, 0, 11'h040, 32'h0,        32'h55AA55AA, 0);
        access(1, 0, 2'b10, 0, 11'h042, 32'h0,        32'h00000000, 1);
        access(1, 0, 2'b01, 1, 11'h023, 32'h0,        32'h00000000, 1);
`else
        access(1, 1, 2'b10, 0, 11'h041, 32'h11111111, 32'h0,        0);
        access(1, 0, 2'b10, 0, 11'h040, 32'h0,        32'h11111111, 0);
        access(1, 0, 2'b10, 0, 11'h042, 32'h0,        32'h11111111, 0);
        access(1, 0, 2'b01, 1, 11'h023, 32'h0,        32'h00008001, 0);
`endif

        // Zero wait states at the highest word
        access(0, 1, 2'b10, 0, 11'h7FC, 32'hCAFEF00D, 32'h0,        0);
        access(0, 1, 2'b10, 0, 11'h000, 32'h01020304, 32'h0,        0);
        access(0, 0, 2'b10, 0, 11'h7FC, 32'h0,        32'hCAFEF00D, 0);
        access(0, 0, 2'b00, 1, 11'h7FF, 32'h0,        32'h000000CA, 0);

        // Three wait states, then a reset in the second WAIT cycle of a store
        access(3, 1, 2'b10, 0, 11'h080, 32'h0BADF00D, 32'h0,        0);
        access(3, 0, 2'b10, 0, 11'h080, 32'h0,        32'h0BADF00D, 0);
        @(negedge clk);
        #1;
        sel = 3; s_wr = 1'b1; s_rd = 1'b0; s_size = 2'b10; s_addr = 11'h040;
        s_wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        check("rstmid.stall_in_wait", {31'b0, m_stall}, 32'd1);
        #1;
        reset = 1'b1; s_wr = 1'b0;
        @(negedge clk);
        check("rstmid.flags", {29'b0, m_stall, m_ready, m_mis}, 32'h0);
        check("rstmid.rdata", m_rdata, 32'h0);
        #1 reset = 1'b0;
        last_rd[3] = 32'h0;
        access(3, 0, 2'b10, 0, 11'h040, 32'h0,        32'h00000000, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data-memory controller for the pipeline's MEM stage. It generalises the single-cycle word memory with several additions:
- byte, halfword and word stores via byte-lane enables;
- sign- or zero-extended sub-word loads;
- configurable depth;
- a configurable number of wait states, with a stall handshake back to the pipeline.

Each access is captured into internal registers and runs through a small state machine. The pipeline holds the MEM-stage instruction while `o_stall` is high.

## Interface
- `DEPTH`, 512: number of 32-bit words; power of two, at least 4.
- `ADDR_WIDTH`, 11: byte-address width; must equal log2(`DEPTH`)+2.
- `WAIT_STATES`, 1: extra cycles per access, 0..7.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `i_mem_read`  in  1  load request.
- `i_mem_write`  in  1  store request; takes priority over a read.
- `i_size`  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `i_unsigned`  in  1  zero-extend sub-word loads; sign-extend when 0.
- `i_address`  in  `ADDR_WIDTH`  byte address.
- `i_mem_write_data`  in  32  store data; right-aligned for byte and half.
- `o_stall`  out  1  hold the MEM stage.
- `o_ready`  out  1  the access completes this cycle.
- `o_mem_read_data`  out  32  extended load result.
- `o_misaligned`  out  1  misaligned-access flag; only active with the macro (see Configuration).

## Operation
- A request is `i_mem_read | i_mem_write`.
- States: IDLE, WAIT, RESP.
  - IDLE with a request: capture address, size, unsigned flag, write data and read/write type.
    - `WAIT_STATES` > 0: go to WAIT with the counter set to `WAIT_STATES` − 1.
    - `WAIT_STATES` = 0: go directly to RESP.
  - WAIT: decrement the counter; go to RESP when the counter is 0.
  - RESP: go to IDLE unconditionally. Request inputs are ignored in RESP, because they still belong to the completing instruction.
- `o_stall` = (IDLE & request) | WAIT. `o_ready` = RESP.
- Addressing:
  - Word index = address[`ADDR_WIDTH`−1:2]; the index wraps naturally over `DEPTH`.
  - Byte lane = address[1:0]. For halves, address[1] selects the upper half.
- Stores:
  - Byte write enables are derived from size and lane; only the enabled lanes change.
  - Write data is replicated to the selected lane(s).
- Loads: the selected byte or half is sign- or zero-extended to 32 bits. Words pass through unchanged.
- `o_mem_read_data` holds the last load result until the next load completes. Stores do not change it.
- Memory contents initialise to zero at power-up. `reset` does not clear the array.

## Timing
- Reset values: state IDLE, counter 0, `o_stall` 0, `o_ready` 0, `o_mem_read_data` 0, `o_misaligned` 0.
- Request in IDLE at cycle T:
  - WAIT occupies cycles T+1 .. T+`WAIT_STATES`.
  - RESP is cycle T+`WAIT_STATES`+1.
  - `o_stall` is high for cycles T .. T+`WAIT_STATES`.
- Store: commits at the edge entering RESP.
- Load:
  - The array is read at the edge entering RESP.
  - `o_mem_read_data` is updated at that same edge and is valid from RESP onward.
- Back-to-back accesses:
  - The next request is accepted in the IDLE cycle after RESP.
  - Throughput is one access per `WAIT_STATES`+2 cycles.
  - A load following a store to the same word returns the new data.
- `reset` mid-access:
  - Return to IDLE next cycle and drop the captured request.
  - If the edge entering RESP has not yet occurred, the store does not commit.
  - `o_mem_read_data` returns to 0.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A half access with address[0]=1, or a word access with address[1:0]≠0, is misaligned.
  - A misaligned access is suppressed: no array write, and a load returns 0.
  - It still takes the full latency.
  - `o_misaligned` is high during its RESP cycle only.
- Not defined:
  - Alignment bits are ignored: halves use only address[1]; words ignore address[1:0].
  - `o_misaligned` is tied to 0.

## Test plan
- `WAIT_STATES`=1, store word 0xDEADBEEF to address 0x010 at cycle 0:
  - `o_stall` is 1 in cycles 0–1 and `o_ready` is 1 in cycle 2.
  - A load from 0x010 then returns 0xDEADBEEF in its RESP cycle.
- Byte lanes, starting from word 0xDEADBEEF:
  - Store byte 0x5A to 0x012: the word becomes 0xDE5ABEEF.
  - Signed byte load from 0x012 returns 0x0000005A.
  - Signed byte load from 0x013 returns 0xFFFFFFDE; unsigned returns 0x000000DE.
- Half access:
  - Store half 0x8001 to 0x022, then signed half load from 0x022 returns 0xFFFF8001.
  - Unsigned half load returns 0x00008001; address 0x020 is unaffected.
- Wrap and latency:
  - `DEPTH`=512, `WAIT_STATES`=0: store to 0x7FC, then load from 0x7FC.
  - Each access has stall high for one cycle, with `o_ready` in the next.
  - The highest word is read back correctly.
- Reset mid-access:
  - `WAIT_STATES`=3: store 0x12345678 to 0x040 and assert `reset` in the second WAIT cycle.
  - All outputs return to 0.
  - A subsequent load from 0x040 returns the old value, 0x00000000.
- With `DMEM_MISALIGN_TRAP_EN` defined:
  - Word store to 0x041 leaves memory unchanged and pulses `o_misaligned` in RESP.
  - Word load from 0x042 returns 0 with `o_misaligned` high for one cycle.
